// File: rtl/sio_pkg.sv
// Shared definitions for the SIO transmit/receive blocks: FSM state type and STAT bit positions.
// Build with SIO_TX_PARITY_EN defined to add the even-parity state.
package sio_pkg;

`ifdef SIO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} sio_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} sio_state_t;
`endif

    localparam int SIO_BUSY   = 0;
    localparam int SIO_FULL   = 1;
    localparam int SIO_EMPTY  = 2;
    localparam int SIO_OVF    = 3;
    localparam int SIO_LVL_LO = 4;
    localparam int SIO_LVL_W  = 3;

endpackage

// File: rtl/sio_tx_if.sv
// CPU-side bundle of the SIO transmitter: write strobe, data, overflow clear, serial line and status.
interface sio_tx_if;
    logic       WE;
    logic [7:0] DIN;
    logic       CLR_OVF;
    logic       TXD;
    logic [7:0] STAT;

    modport master (output WE, DIN, CLR_OVF, input TXD, STAT);
    modport slave  (input WE, DIN, CLR_OVF, output TXD, STAT);
endinterface

// File: rtl/sio_fifo.sv
// Small synchronous FIFO shared by the SIO transmit and receive paths.
module sio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [LW-1:0]    level_q;
    logic             wr, rd;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign wr      = push_i && (!full_o || pop_i);
    assign rd      = pop_i && !empty_o;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign dout_o  = mem_q[head_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[tail_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr) begin
                tail_q <= tail_q + PW'(1);
            end
            if (rd) begin
                head_q <= head_q + PW'(1);
            end
            level_q <= level_q + LW'(wr) - LW'(rd);
        end
    end
endmodule

// File: rtl/sio_tx.sv
// SIO serial transmitter: queues CPU writes and shifts them out as async 8N1 frames, LSB first.
// Defining SIO_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module sio_tx
    import sio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     CLK,
    input  logic     RESET,
    sio_tx_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);

    sio_state_t       state_q, state_d;
    logic [7:0]       baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       stat_q, stat_d;
`ifdef SIO_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             push, pop, fifo_full, fifo_empty, baud_end;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] level, level_d;

    sio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.DIN),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (baud_q == 8'(CLKS_PER_BIT-1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            stat_q  <= 8'b0000_0100;
`ifdef SIO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            stat_q  <= stat_d;
`ifdef SIO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef SIO_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = baud_end ? 8'd0 : baud_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = 8'd0;
                    state_d = START;
`ifdef SIO_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SIO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SIO_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (baud_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
`ifdef SIO_TX_PARITY_EN
                        par_d   = ^fifo_dout;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef SIO_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
        push  = bus.WE && (!fifo_full || pop);
        ovf_d = ovf_q;
        if (bus.CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (bus.WE && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        // Status is built from post-edge values so the register matches the state after the edge.
        level_d                      = level + LVL_W'(push) - LVL_W'(pop);
        stat_d                       = 8'b0;
        stat_d[SIO_BUSY]             = (state_d != IDLE);
        stat_d[SIO_FULL]             = (level_d == LVL_W'(FIFO_DEPTH));
        stat_d[SIO_EMPTY]            = (level_d == '0);
        stat_d[SIO_OVF]              = ovf_d;
        stat_d[SIO_LVL_LO +: SIO_LVL_W] = SIO_LVL_W'(level_d);
    end

    assign bus.TXD  = txd_q;
    assign bus.STAT = stat_q;
endmodule

// File: tb/tb_sio_tx.sv
// Randomized bench for sio_tx: every cycle TXD and STAT are compared with a frame-level model.
// Honours SIO_TX_PARITY_EN to match the parity build.
module tb_sio_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef SIO_TX_PARITY_EN
    localparam int FRAME_SLOTS = 11;
`else
    localparam int FRAME_SLOTS = 10;
`endif
    localparam int FRAME_LEN = CPB * FRAME_SLOTS;

    logic clk = 1'b0;
    logic reset;
    sio_tx_if bus();

    sio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] modelQ[$];
    logic [7:0] curByte;
    bit         active;
    int         t;
    bit         ovf;
    logic       modelTxd;
    logic [7:0] modelStat;
    int         vectorCount = 0;
    int         miscompareCount = 0;

    // Line level at cycle tt of a frame: start, 8 data LSB first, optional parity, stop.
    function automatic logic frameBit(logic [7:0] b, int tt);
        int slot;
        slot = tt / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef SIO_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic we, input logic [7:0] din, input logic clr, input logic rst);
        bit popNow, wasFull, ovfSet;
        ovfSet = 1'b0;
        if (rst) begin
            modelQ.delete();
            active = 1'b0;
            t      = 0;
            ovf    = 1'b0;
        end else begin
            popNow  = (modelQ.size() > 0) && (!active || t == FRAME_LEN-1);
            wasFull = (modelQ.size() == DEPTH);
            if (popNow) begin
                curByte = modelQ.pop_front();
                active  = 1'b1;
                t       = 0;
            end else if (active) begin
                if (t == FRAME_LEN-1) active = 1'b0;
                else t++;
            end
            if (we) begin
                if (!wasFull || popNow) modelQ.push_back(din);
                else ovfSet = 1'b1;
            end
            if (clr) ovf = 1'b0;
            if (ovfSet) ovf = 1'b1;
        end
        modelTxd  = active ? frameBit(curByte, t) : 1'b1;
        modelStat = {1'b0, 3'(modelQ.size()), ovf, modelQ.size() == 0, modelQ.size() == DEPTH, active};
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] din, input logic clr, input logic rst);
        bus.WE      = we;
        bus.DIN     = din;
        bus.CLR_OVF = clr;
        reset       = rst;
        @(posedge clk);
        modelEdge(we, din, clr, rst);
        @(negedge clk);
        checkOutput("TXD", {7'b0, bus.TXD}, {7'b0, modelTxd});
        checkOutput("STAT", bus.STAT, modelStat);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        bus.WE      = 1'b0;
        bus.DIN     = 8'h00;
        bus.CLR_OVF = 1'b0;
        reset       = 1'b1;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("RST_STAT", bus.STAT, 8'h04);
        checkOutput("RST_TXD", {7'b0, bus.TXD}, 8'h01);

        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("A5_START", {7'b0, bus.TXD}, 8'h00);
        idleCycles(FRAME_LEN + 8);
        checkOutput("A5_DONE", bus.STAT, 8'h04);

        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        idleCycles(2 * FRAME_LEN + 8);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        checkOutput("OVF_SET", {7'b0, bus.STAT[3]}, 8'h01);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("OVF_HOLD", {7'b0, bus.STAT[3]}, 8'h01);
        idleCycles(5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("OVF_CLR", {7'b0, bus.STAT[3]}, 8'h00);
        idleCycles(5 * FRAME_LEN + 8);

`ifdef SIO_TX_PARITY_EN
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
        idleCycles(FRAME_LEN + 4);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        idleCycles(FRAME_LEN + 4);
`endif

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC3 ^ i), 1'b0, 1'b0);
        idleCycles(CPB * 4 - 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("MID_RST_TXD", {7'b0, bus.TXD}, 8'h01);
        checkOutput("MID_RST_STAT", bus.STAT, 8'h04);
        idleCycles(FRAME_LEN + 8);

        for (int i = 0; i < 3000; i++) begin
            int weChance;
            weChance = ((i / 200) % 2 == 0) ? 10 : 60;
            applyStimulus($urandom_range(99) < weChance, 8'($urandom), $urandom_range(49) == 0,
                          $urandom_range(499) == 0);
        end
        idleCycles(DEPTH * FRAME_LEN + FRAME_LEN);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end
endmodule
